// File: rtl/myfilter_pkg.sv
// Shared constants for the I2C bus-line front end.
package myfilter_pkg;
  localparam int unsigned I2C_SYNC_STAGES = 2;
  localparam int unsigned I2C_FILTER_LEN  = 3;
  localparam logic        I2C_LINE_IDLE   = 1'b1;
endpackage

// File: rtl/i2c_line_filter.sv
// One bus line: multi-flop synchroniser followed by a stability filter that
// only follows the synchronised level after FILTER_LEN consecutive mismatches.
module i2c_line_filter
  import myfilter_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = I2C_SYNC_STAGES,
  parameter int unsigned FILTER_LEN  = I2C_FILTER_LEN
) (
  input  logic clk,
  input  logic rst,
  input  logic line_in,
  output logic line_f
);

  localparam int unsigned CW = $clog2(FILTER_LEN + 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CW-1:0]          cnt;
  logic                   line_s;

  assign line_s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= {SYNC_STAGES{I2C_LINE_IDLE}};
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], line_in};
    end
  end

  // Any match resets the run, so a broken mismatch starts again from zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      line_f <= I2C_LINE_IDLE;
      cnt    <= '0;
    end else if (line_s == line_f) begin
      cnt <= '0;
    end else if (cnt == CW'(FILTER_LEN - 1)) begin
      line_f <= ~line_f;
      cnt    <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/i2c_cond_detect.sv
// I2C front end: filtered SCL/SDA, registered edge and START/STOP pulses,
// and a bus-busy flag spanning START..STOP.
module i2c_cond_detect
  import myfilter_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = I2C_SYNC_STAGES,
  parameter int unsigned FILTER_LEN  = I2C_FILTER_LEN
) (
  input  logic clk,
  input  logic rst,
  input  logic scl_in,
  input  logic sda_in,
  output logic scl_rise_out,
  output logic scl_fall_out,
  output logic start_out,
  output logic stop_out,
  output logic sda_out,
  output logic busy_out
);

  logic scl_f, sda_f;
  logic scl_p, sda_p;
  logic scl_rise, scl_fall, start_c, stop_c;

  i2c_line_filter #(
    .SYNC_STAGES(SYNC_STAGES),
    .FILTER_LEN (FILTER_LEN)
  ) u_scl_filter (
    .clk    (clk),
    .rst    (rst),
    .line_in(scl_in),
    .line_f (scl_f)
  );

  i2c_line_filter #(
    .SYNC_STAGES(SYNC_STAGES),
    .FILTER_LEN (FILTER_LEN)
  ) u_sda_filter (
    .clk    (clk),
    .rst    (rst),
    .line_in(sda_in),
    .line_f (sda_f)
  );

  // START/STOP require SCL stable high across both cycles, so a same-cycle
  // SCL and SDA change only ever reports the SCL edge.
  always_comb begin
    scl_rise = ~scl_p & scl_f;
    scl_fall = scl_p & ~scl_f;
    start_c  = scl_p & scl_f & sda_p & ~sda_f;
    stop_c   = scl_p & scl_f & ~sda_p & sda_f;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_p        <= I2C_LINE_IDLE;
      sda_p        <= I2C_LINE_IDLE;
      scl_rise_out <= 1'b0;
      scl_fall_out <= 1'b0;
      start_out    <= 1'b0;
      stop_out     <= 1'b0;
      busy_out     <= 1'b0;
    end else begin
      scl_p        <= scl_f;
      sda_p        <= sda_f;
      scl_rise_out <= scl_rise;
      scl_fall_out <= scl_fall;
      start_out    <= start_c;
      stop_out     <= stop_c;
      if (start_c) begin
        busy_out <= 1'b1;
      end else if (stop_c) begin
        busy_out <= 1'b0;
      end
    end
  end

  // The previous-cycle SDA copy is already the registered filtered level.
  assign sda_out = sda_p;

endmodule

// File: tb/tb_i2c_cond_detect.sv
// Directed and random bench for i2c_cond_detect against a sample-window model.
module tb_i2c_cond_detect;
  localparam int S = 2;
  localparam int F = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic scl_in = 1'b1;
  logic sda_in = 1'b1;
  logic scl_rise_out, scl_fall_out, start_out, stop_out, sda_out, busy_out;

  i2c_cond_detect #(
    .SYNC_STAGES(S),
    .FILTER_LEN (F)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .scl_in      (scl_in),
    .sda_in      (sda_in),
    .scl_rise_out(scl_rise_out),
    .scl_fall_out(scl_fall_out),
    .start_out   (start_out),
    .stop_out    (stop_out),
    .sda_out     (sda_out),
    .busy_out    (busy_out)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Model: raw samples per edge; a filtered level flips once the last F
  // synchronised samples (raw delayed by S edges) all differ from it.
  bit hs[$];
  bit hd[$];
  bit m_scl_p, m_scl_f, m_sda_p, m_sda_f, m_busy;

  int n_rise, n_fall, n_start, n_stop, phase_cyc, first_start;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  function automatic bit samp(input bit is_sda, input int back);
    int idx;
    idx = (is_sda ? hd.size() : hs.size()) - 1 - back;
    if (idx < 0) return 1'b1;
    return is_sda ? hd[idx] : hs[idx];
  endfunction

  function automatic bit next_f(input bit is_sda, input bit cur);
    for (int j = 0; j < F; j++)
      if (samp(is_sda, S + j) == cur) return cur;
    return ~cur;
  endfunction

  task automatic model_reset();
    hs.delete();
    hd.delete();
    m_scl_p = 1'b1; m_scl_f = 1'b1;
    m_sda_p = 1'b1; m_sda_f = 1'b1;
    m_busy  = 1'b0;
  endtask

  task automatic clear_counts();
    n_rise = 0; n_fall = 0; n_start = 0; n_stop = 0;
    phase_cyc = 0; first_start = -1;
  endtask

  task automatic cycle(input bit scl, input bit sda);
    bit e_rise, e_fall, e_start, e_stop, nf_scl, nf_sda;
    scl_in = scl;
    sda_in = sda;
    @(posedge clk);
    hs.push_back(scl);
    hd.push_back(sda);
    if (hs.size() > 16) begin
      void'(hs.pop_front());
      void'(hd.pop_front());
    end
    #1;
    e_rise  = !m_scl_p && m_scl_f;
    e_fall  = m_scl_p && !m_scl_f;
    e_start = m_scl_p && m_scl_f && m_sda_p && !m_sda_f;
    e_stop  = m_scl_p && m_scl_f && !m_sda_p && m_sda_f;
    if (e_start) m_busy = 1'b1;
    else if (e_stop) m_busy = 1'b0;
    check("scl_rise", scl_rise_out, e_rise);
    check("scl_fall", scl_fall_out, e_fall);
    check("start", start_out, e_start);
    check("stop", stop_out, e_stop);
    check("sda_out", sda_out, m_sda_f);
    check("busy", busy_out, m_busy);
    if (scl_rise_out) n_rise++;
    if (scl_fall_out) n_fall++;
    if (stop_out) n_stop++;
    if (start_out) begin
      n_start++;
      if (first_start < 0) first_start = phase_cyc;
    end
    phase_cyc++;
    nf_scl = next_f(1'b0, m_scl_f);
    nf_sda = next_f(1'b1, m_sda_f);
    m_scl_p = m_scl_f; m_scl_f = nf_scl;
    m_sda_p = m_sda_f; m_sda_f = nf_sda;
  endtask

  task automatic hold(input bit scl, input bit sda, input int n);
    repeat (n) cycle(scl, sda);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    scl_in = 1'b1;
    sda_in = 1'b1;
    #1;
    check("rst_rise", scl_rise_out, 0);
    check("rst_fall", scl_fall_out, 0);
    check("rst_start", start_out, 0);
    check("rst_stop", stop_out, 0);
    check("rst_sda", sda_out, 1);
    check("rst_busy", busy_out, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
  endtask

  initial begin
    logic [8:0] byte_bits;
    model_reset();
    @(posedge clk);
    #1;
    do_reset();

    // Idle after reset
    clear_counts();
    hold(1, 1, 20);
    check("idle_pulses", n_rise + n_fall + n_start + n_stop, 0);
    check("idle_busy", busy_out, 0);
    check("idle_sda", sda_out, 1);

    // START, 9 bits, STOP
    clear_counts();
    hold(1, 0, 8);
    check("start_count", n_start, 1);
    check("start_latency", first_start, S + F);
    check("start_busy", busy_out, 1);
    clear_counts();
    byte_bits = {8'($urandom), 1'b0};
    for (int i = 8; i >= 0; i--) begin
      hold(0, byte_bits[i], 6);
      hold(1, byte_bits[i], 6);
    end
    hold(1, 1, 8);
    check("byte_rises", n_rise, 9);
    check("byte_falls", n_fall, 9);
    check("stop_count", n_stop, 1);
    check("stop_starts", n_start, 0);
    check("stop_busy", busy_out, 0);

    // Glitch rejection
    hold(1, 1, 6);
    clear_counts();
    hold(0, 1, F - 1);
    hold(1, 1, 10);
    check("glitch_edges", n_rise + n_fall, 0);
    clear_counts();
    hold(0, 1, F);
    hold(1, 1, 10);
    check("pulse_falls", n_fall, 1);
    check("pulse_rises", n_rise, 1);

    // Repeated START
    hold(1, 0, 8);
    hold(0, 0, 6);
    hold(0, 1, 6);
    hold(1, 1, 8);
    clear_counts();
    hold(1, 0, 8);
    check("rstart_count", n_start, 1);
    check("rstart_busy", busy_out, 1);
    hold(0, 0, 6);
    hold(1, 0, 6);
    hold(1, 1, 8);
    check("rstart_stop_busy", busy_out, 0);

    // Simultaneous SCL and SDA fall
    clear_counts();
    hold(0, 0, 8);
    check("simul_fall", n_fall, 1);
    check("simul_start", n_start, 0);
    hold(0, 1, 6);
    hold(1, 1, 8);
    check("simul_stop", n_stop, 0);

    // Reset in the middle of an SDA filter count
    hold(1, 1, 6);
    hold(1, 0, S + F - 1);
    do_reset();
    clear_counts();
    hold(1, 1, 12);
    check("midrst_start", n_start, 0);
    check("midrst_sda", sda_out, 1);

    // Random line activity
    for (int k = 0; k < 60; k++)
      hold(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(1, 6));
    hold(1, 1, 10);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/i2c_cond_detect.md
# i2c_cond_detect

- Upstream front end of the I2C slave, directly feeding `i2c_fsm`.
- Synchronises the asynchronous `scl_in`/`sda_in` bus lines to `clk` and removes glitches shorter than a programmable length.
- Produces single-cycle `scl_rise_out`, `scl_fall_out`, `start_out` and `stop_out` pulses, a clean `sda_out` level, and a `busy_out` flag. `i2c_fsm` and the shift-register datapath consume these.

## Interface
- `SYNC_STAGES`, default 2: synchroniser flop count per line, ≥2.
- `FILTER_LEN`, default 3: consecutive stable cycles required before a filtered line changes, ≥1.
- `clk  in  1`: system clock; the block has one clock.
- `rst  in  1`: reset, asynchronous, active-high.
- `scl_in  in  1`: raw SCL line, asynchronous to `clk`.
- `sda_in  in  1`: raw SDA line, asynchronous to `clk`.
- `scl_rise_out  out  1`: one-cycle pulse on a filtered SCL 0→1 transition.
- `scl_fall_out  out  1`: one-cycle pulse on a filtered SCL 1→0 transition.
- `start_out  out  1`: one-cycle pulse on a START or repeated START.
- `stop_out  out  1`: one-cycle pulse on a STOP.
- `sda_out  out  1`: filtered SDA level, used for bit sampling.
- `busy_out  out  1`: high between START and STOP.

## Operation
- **Per line (SCL, SDA):** `SYNC_STAGES`-flop synchroniser, then a stability filter.
  - Filter holds a registered level `f` and a counter `cnt` of width `$clog2(FILTER_LEN+1)`.
  - Synchronised value == `f`: `cnt` is cleared.
  - Synchronised value != `f`: `cnt` increments.
  - On the cycle `cnt == FILTER_LEN-1` while the mismatch persists, `f` toggles and `cnt` clears.
  - A mismatch that breaks before this point restarts the count from 0 at the next mismatch.
- **Edge/condition logic:** compares filtered levels against their previous-cycle copies `scl_p` and `sda_p`.
  - `scl_rise` = `!scl_p & scl_f`; `scl_fall` = `scl_p & !scl_f`.
  - `start` = `scl_p & scl_f & sda_p & !sda_f`, i.e. SDA falls while SCL is stable high.
  - `stop` = `scl_p & scl_f & !sda_p & sda_f`, i.e. SDA rises while SCL is stable high.
- **All pulse outputs are registered:** each is high for exactly one `clk` cycle per event.
- **`busy_out`:** set on the edge that asserts `start_out`, cleared on the edge that asserts `stop_out`.
  - A repeated START while busy pulses `start_out`; `busy_out` stays 1.
  - A STOP while idle pulses `stop_out`; `busy_out` stays 0.
- **Simultaneous SCL and SDA filtered change in one cycle:** only the SCL edge pulse fires. No START or STOP is reported.
- **`start_out` and `stop_out`** are mutually exclusive by construction.
- **No pulse on the first cycle after reset deassertion:** reset levels match the idle bus, so no reported event can occur then.

## Timing
- **Reset values:**
  - Synchroniser flops, `scl_f`, `sda_f`, `scl_p`, `sda_p`: 1.
  - Counters: 0.
  - `sda_out`: 1.
  - `scl_rise_out`, `scl_fall_out`, `start_out`, `stop_out`, `busy_out`: 0.
- **Reset mid-operation:** all state returns to the values above immediately (asynchronous). Any in-progress filter count is discarded.
- **Latency:** let edge 0 be the first `clk` edge sampling a new, clean raw level.
  - The filtered level updates at edge `SYNC_STAGES+FILTER_LEN-1`.
  - The corresponding pulse and `sda_out` become visible after edge `SYNC_STAGES+FILTER_LEN`. With defaults this is edge 5.
- **Glitch rejection:** a raw deviation lasting fewer than `FILTER_LEN` consecutive synchronised cycles never changes `f` and produces no pulse.
- **Minimum spacing:** two events on the same line are at least `FILTER_LEN` cycles apart at the outputs.

## Structure
- **Shared package** (`myfilter_pkg`, with `myfilter.svh`) holds:
  - `I2C_SYNC_STAGES` and `I2C_FILTER_LEN` default constants.
  - The idle-level constant `I2C_LINE_IDLE = 1'b1`.
- **Sub-module `i2c_line_filter`** (parameters `SYNC_STAGES`, `FILTER_LEN`):
  - Contains the synchroniser plus stability filter.
  - Instantiated twice, once for SCL and once for SDA.
- **Top level** contains the previous-level registers, the edge/condition logic, the output registers and the `busy_out` flag.

## Test plan
- **Reset:** assert `rst` with lines at 1, release, hold lines 1 for 20 cycles.
  - All pulses stay 0, `busy_out`=0, `sda_out`=1.
- **START then byte then STOP** with defaults:
  - SDA 1→0 with SCL high gives `start_out` exactly 1 cycle, 5 edges later, and `busy_out`=1.
  - 9 SCL clocks give 9 `scl_rise_out` and 9 `scl_fall_out` pulses.
  - SDA 0→1 with SCL high gives `stop_out` for 1 cycle and `busy_out`=0.
- **Glitch rejection:** 2-cycle low glitch on SCL with `FILTER_LEN`=3.
  - No `scl_fall_out` or `scl_rise_out`.
  - A 3-cycle low pulse yields exactly one fall and one rise.
- **Repeated START:** while busy, SCL high then SDA falls.
  - `start_out` pulses once and `busy_out` stays 1.
- **Simultaneous change:** SCL 1→0 and SDA 1→0 in the same raw cycle.
  - `scl_fall_out` only; `start_out` stays 0.
- **Reset mid-count:** SDA held low for 2 of 3 filter cycles, then `rst` pulses.
  - After release `sda_out`=1 and no `start_out` fires.
